// File: rtl/pipeline_perf_monitor_pkg.sv
// Shared types and constants for the pipeline performance monitor.
// Channel indices follow the CPU hookup: stall on 0, flush on 1.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STALL_CH = 0;
  localparam int FLUSH_CH = 1;

  // Select covers the cycle counter plus every event channel.
  function automatic int sel_w(input int num_events);
    return (num_events < 1) ? 1 : $clog2(num_events + 1);
  endfunction

endpackage

// File: rtl/pipeline_perf_monitor_counter.sv
// Single event counter: synchronous clear, freeze, saturate-or-wrap, sticky overflow.
// One-cycle update latency; no backpressure (inc is a plain strobe).
module perf_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             frz_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (inc_i && !frz_i) begin
      if (&cnt_o) begin
        ovf_o <= 1'b1;
        cnt_o <= SATURATE ? cnt_o : '0;
      end else begin
        cnt_o <= cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Cycle and qualified-event counters with a cycle budget, freeze-on-done and a registered read port.
// Read data lags rd_sel_i by one cycle; start_i low pauses counting, no other backpressure.
module pipeline_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int NUM_EVENTS = 2,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 30,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic [NUM_EVENTS-1:0]         event_i,
  input  logic [NUM_EVENTS-1:0]         inhibit_i,
  input  logic [sel_w(NUM_EVENTS)-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]              rd_data_o,
  output logic [CNT_W-1:0]              cycle_o,
  output logic                          done_o,
  output logic [NUM_EVENTS:0]           ovf_o
);

  localparam int                SEL_W     = sel_w(NUM_EVENTS);
  localparam bit                HAS_LIMIT = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0]  LAST_CYC  = CNT_W'(MAX_CYCLES - 1);

  state_t              state_q, state_d;
  logic                count_en;
  logic                last_cyc;
  logic                frozen;
  logic [NUM_EVENTS:0] inc;
  logic [CNT_W-1:0]    cnt [NUM_EVENTS+1];
  logic [CNT_W-1:0]    rd_mux;

  // IDLE counts too: the edge that leaves IDLE is the first counted cycle.
  assign frozen   = (state_q == DONE);
  assign count_en = start_i && !clear_i && !frozen;
  assign last_cyc = HAS_LIMIT && (cnt[0] == LAST_CYC);
  assign inc      = {event_i & ~inhibit_i & {NUM_EVENTS{count_en}}, count_en};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = last_cyc ? DONE : RUN;
        RUN:     if (start_i && last_cyc) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  for (genvar k = 0; k <= NUM_EVENTS; k++) begin : g_cnt
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (inc[k]),
      .frz_i (frozen),
      .cnt_o (cnt[k]),
      .ovf_o (ovf_o[k])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k <= NUM_EVENTS; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_mux = cnt[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) rd_data_o <= '0;
    else                  rd_data_o <= rd_mux;
  end

  assign cycle_o = cnt[0];
  assign done_o  = frozen;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench: default monitor for budget/inhibit/pause/clear, plus two 4-bit unlimited monitors for saturate vs wrap.
module tb_pipeline_perf_monitor;
  import perf_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, clear;
  logic [1:0]  ev, inh, rd_sel;
  logic [31:0] rd_data, cycle;
  logic        done;
  logic [2:0]  ovf;

  logic        st4;
  logic [1:0]  ev4, rd_sel4, zero2;
  logic        zero1;
  logic [3:0]  rd_s, cyc_s, rd_w, cyc_w;
  logic        done_s, done_w;
  logic [2:0]  ovf_s, ovf_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_perf_monitor #(.NUM_EVENTS(2), .CNT_W(32), .MAX_CYCLES(30), .SATURATE(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev), .inhibit_i(inh),
    .rd_sel_i(rd_sel), .rd_data_o(rd_data), .cycle_o(cycle), .done_o(done), .ovf_o(ovf));

  pipeline_perf_monitor #(.NUM_EVENTS(2), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1'b1)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(st4), .clear_i(zero1), .event_i(ev4), .inhibit_i(zero2),
    .rd_sel_i(rd_sel4), .rd_data_o(rd_s), .cycle_o(cyc_s), .done_o(done_s), .ovf_o(ovf_s));

  pipeline_perf_monitor #(.NUM_EVENTS(2), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1'b0)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(st4), .clear_i(zero1), .event_i(ev4), .inhibit_i(zero2),
    .rd_sel_i(rd_sel4), .rd_data_o(rd_w), .cycle_o(cyc_w), .done_o(done_w), .ovf_o(ovf_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; ev = '0; inh = '0; rd_sel = '0;
    st4 = 1'b0; ev4 = '0; rd_sel4 = '0; zero1 = 1'b0; zero2 = '0;
    step(3);
    rst = 1'b0;
    chk("reset_cycle", cycle, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_ovf", {29'd0, ovf}, 0);
    chk("reset_rd", rd_data, 0);

    // Budget run: stall every third cycle, no flush.
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ev[STALL_CH] = (i % 3 == 0);
      ev[FLUSH_CH] = 1'b0;
      step();
      if (i == 28) begin
        chk("pre_done_cycle", cycle, 29);
        chk("pre_done_flag", {31'd0, done}, 0);
      end
    end
    chk("budget_cycle", cycle, 30);
    chk("budget_done", {31'd0, done}, 1);
    ev = 2'b11;
    rd_sel = 2'd1; step();
    chk("budget_stall", rd_data, 10);
    rd_sel = 2'd2; step();
    chk("budget_flush", rd_data, 0);
    rd_sel = 2'd0; step();
    chk("frozen_cycle_rd", rd_data, 30);
    chk("frozen_cycle", cycle, 30);
    rd_sel = 2'd3; step();
    chk("rd_out_of_range", rd_data, 0);
    chk("budget_ovf", {29'd0, ovf}, 0);

    // Clear while DONE, with start held high.
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b0; ev = '0;
    chk("clr_done_cycle", cycle, 0);
    chk("clr_done_flag", {31'd0, done}, 0);
    chk("clr_done_rd", rd_data, 0);
    for (int k = 0; k < 3; k++) begin
      rd_sel = 2'(k); step();
      chk($sformatf("sweep_sel%0d", k), rd_data, 0);
    end
    chk("idle_hold_cycle", cycle, 0);

    // Inhibit: 8 raw stalls on even cycles, half inhibited; one flush at cycle 5.
    start = 1'b1; rd_sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      ev[STALL_CH]  = (i % 2 == 0);
      inh[STALL_CH] = (i % 4 == 0);
      ev[FLUSH_CH]  = (i == 5);
      inh[FLUSH_CH] = 1'b0;
      step();
      if (i == 9) chk("rd_latency", rd_data, 9);
    end
    chk("inh_cycle", cycle, 16);

    // Pause five cycles with events present.
    start = 1'b0; ev = 2'b11; inh = '0;
    rd_sel = 2'd1; step();
    chk("inh_stall", rd_data, 4);
    rd_sel = 2'd2; step();
    chk("inh_flush", rd_data, 1);
    step(3);
    chk("pause_cycle", cycle, 16);
    chk("pause_done", {31'd0, done}, 0);

    // Resume: budget lands five cycles later than an uninterrupted run.
    start = 1'b1; ev = 2'b01;
    step(13);
    chk("resume_cycle29", cycle, 29);
    chk("resume_not_done", {31'd0, done}, 0);
    step();
    chk("resume_cycle30", cycle, 30);
    chk("resume_done", {31'd0, done}, 1);
    start = 1'b0; rd_sel = 2'd1; step();
    chk("resume_stall", rd_data, 18);

    // Clear mid-run, concurrent with start.
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; ev = '0;
    step(3);
    chk("run_again", cycle, 3);
    clear = 1'b1; step();
    chk("clr_run_cycle", cycle, 0);
    chk("clr_run_done", {31'd0, done}, 0);
    clear = 1'b0; step();
    chk("count_after_clr", cycle, 1);

    rst = 1'b1; clear = 1'b1; step();
    rst = 1'b0; clear = 1'b0; start = 1'b0;
    chk("rst_clr_cycle", cycle, 0);
    chk("rst_clr_rd", rd_data, 0);
    chk("rst_clr_done", {31'd0, done}, 0);

    // 4-bit unlimited monitors, event on every cycle.
    st4 = 1'b1; ev4 = 2'b11;
    step(15);
    chk("sat_cyc15", {28'd0, cyc_s}, 15);
    chk("sat_no_ovf", {29'd0, ovf_s}, 0);
    chk("wrap_no_ovf", {29'd0, ovf_w}, 0);
    step(5);
    chk("sat_cyc20", {28'd0, cyc_s}, 15);
    chk("sat_ovf", {29'd0, ovf_s}, 7);
    chk("wrap_cyc20", {28'd0, cyc_w}, 4);
    chk("wrap_ovf", {29'd0, ovf_w}, 7);
    chk("unlimited_done", {30'd0, done_s, done_w}, 0);
    st4 = 1'b0; rd_sel4 = 2'd1; step();
    chk("sat_ch0", {28'd0, rd_s}, 15);
    chk("wrap_ch0", {28'd0, rd_w}, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
